// File: rtl/mux_scan_ctrl_if.sv
// Handshake and data bundle between the scan sequencer
// and the environment holding the 16x1 mux.
interface mux_scan_ctrl_if;
  logic        i_start;
  logic        i_continuous;
  logic        i_abort;
  logic        i_mux_out;
  logic [3:0]  o_sel;
  logic        o_busy;
  logic [15:0] o_data;
  logic        o_data_valid;

  modport master (
    input  i_start,
    input  i_continuous,
    input  i_abort,
    input  i_mux_out,
    output o_sel,
    output o_busy,
    output o_data,
    output o_data_valid
  );

  modport slave (
    output i_start,
    output i_continuous,
    output i_abort,
    output i_mux_out,
    input  o_sel,
    input  o_busy,
    input  o_data,
    input  o_data_valid
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps a 16x1 mux through all channels, lets each settle,
// samples its bit and publishes the 16-bit word.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  mux_scan_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [3:0] CNT_LAST =
    4'(SETTLE_CYC - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_sel;
  logic [3:0]  w_sel_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [14:0] r_cap;
  logic [14:0] w_cap_nxt;
  logic [15:0] r_data;
  logic [15:0] w_data_nxt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_cap   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cap   <= w_cap_nxt;
      r_data  <= w_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_cap_nxt   = r_cap;
    w_data_nxt  = r_data;
    if (bus.i_abort) begin
      w_state_nxt = IDLE;
      w_sel_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            w_state_nxt = SETTLE;
            w_sel_nxt   = '0;
            w_cnt_nxt   = '0;
          end
        end
        SETTLE: begin
          w_cnt_nxt = r_cnt + 4'd1;
          if (r_cnt == CNT_LAST)
            w_state_nxt = SAMPLE;
        end
        SAMPLE: begin
          // Channel 15 exits before the increment, so sel never wraps
          if (r_sel == 4'hF) begin
            w_data_nxt  = {bus.i_mux_out, r_cap};
            w_state_nxt = DONE;
          end else begin
            w_cap_nxt[r_sel] = bus.i_mux_out;
            w_sel_nxt        = r_sel + 4'd1;
            w_cnt_nxt        = '0;
            w_state_nxt      = SETTLE;
          end
        end
        DONE: begin
          if (bus.i_continuous) begin
            w_state_nxt = SETTLE;
            w_sel_nxt   = '0;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign bus.o_sel        = r_sel;
  assign bus.o_busy       = (r_state != IDLE);
  assign bus.o_data       = r_data;
  assign bus.o_data_valid = (r_state == DONE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Randomized bench for mux_scan_ctrl with a timing/word
// reference model and two settle configurations.
module tb_mux_scan_ctrl;

  localparam int S2   = 2;
  localparam int S1   = 1;
  localparam int LAT2 = 16 * (S2 + 1);
  localparam int LAT1 = 16 * (S1 + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_scan_ctrl_if if2 ();
  mux_scan_ctrl_if if1 ();

  logic [15:0] in2 = '0;
  logic [15:0] in1 = '0;
  logic [15:0] exp_data = '0;
  int total = 0;
  int bad   = 0;

  // Zero-delay mux for the SETTLE_CYC=2 unit
  assign if2.i_mux_out = in2[if2.o_sel];

  // 1-cycle-latency mux: garbage right after sel moves
  logic [3:0] r_sel1_d = '0;
  logic       r_pipe   = 1'b0;
  logic       r_junk   = 1'b0;
  always @(posedge clk) begin
    r_sel1_d <= if1.o_sel;
    r_pipe   <= in1[if1.o_sel];
    r_junk   <= 1'($urandom);
  end
  assign if1.i_mux_out =
    (if1.o_sel == r_sel1_d) ? r_pipe : r_junk;

  mux_scan_ctrl #(.SETTLE_CYC(S2)) u_dut2 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (if2)
  );

  mux_scan_ctrl #(.SETTLE_CYC(S1)) u_dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (if1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_scan(input logic [15:0] w,
                          input int ign_at);
    int n;
    int first;
    int pulses;
    in2 = w;
    if2.i_start = 1'b1;
    step();
    if2.i_start = 1'b0;
    chk("busy_after_start", 32'(if2.o_busy), 1);
    n = 0;
    first = -1;
    pulses = 0;
    while (if2.o_busy && n < 200) begin
      if2.i_start = (n == ign_at);
      step();
      n++;
      if (if2.o_data_valid) begin
        pulses++;
        if (first < 0) first = n;
        chk("scan_data", 32'(if2.o_data), 32'(w));
      end
    end
    if2.i_start = 1'b0;
    chk("valid_edge", first, LAT2);
    chk("valid_pulses", pulses, 1);
    chk("idle_edge", n, LAT2 + 1);
    exp_data = w;
  endtask

  task automatic abort_scan(input logic [15:0] w,
                            input int k);
    int pulses;
    in2 = w;
    if2.i_start = 1'b1;
    step();
    if2.i_start = 1'b0;
    repeat (k) step();
    chk("sel_track", 32'(if2.o_sel), k / (S2 + 1));
    if2.i_abort = 1'b1;
    step();
    if2.i_abort = 1'b0;
    chk("abort_busy", 32'(if2.o_busy), 0);
    chk("abort_sel", 32'(if2.o_sel), 0);
    chk("abort_valid", 32'(if2.o_data_valid), 0);
    chk("abort_data", 32'(if2.o_data), 32'(exp_data));
    pulses = 0;
    repeat (60) begin
      step();
      if (if2.o_data_valid) pulses++;
    end
    chk("abort_no_valid", pulses, 0);
  endtask

  task automatic run_cont();
    int n;
    int v;
    int t0;
    if2.i_continuous = 1'b1;
    in2 = 16'hFFFF;
    if2.i_start = 1'b1;
    step();
    if2.i_start = 1'b0;
    n = 0;
    v = 0;
    t0 = -1;
    while (v < 2 && n < 300) begin
      step();
      n++;
      if (if2.o_data_valid) begin
        if (v == 0) begin
          chk("cont_first_edge", n, LAT2);
          chk("cont_w0", 32'(if2.o_data), 32'hFFFF);
          in2 = 16'h1234;
          t0 = n;
        end else begin
          chk("cont_w1", 32'(if2.o_data), 32'h1234);
          chk("cont_period", n - t0, LAT2 + 1);
          if2.i_continuous = 1'b0;
        end
        v++;
      end
    end
    if2.i_continuous = 1'b0;
    chk("cont_pulses", v, 2);
    step();
    chk("cont_stop_busy", 32'(if2.o_busy), 0);
    exp_data = 16'h1234;
  endtask

  task automatic run_scan1(input logic [15:0] w);
    int n;
    int first;
    in1 = w;
    if1.i_start = 1'b1;
    step();
    if1.i_start = 1'b0;
    n = 0;
    first = -1;
    while (if1.o_busy && n < 200) begin
      step();
      n++;
      if (if1.o_data_valid) begin
        if (first < 0) first = n;
        chk("settle_data", 32'(if1.o_data), 32'(w));
      end
    end
    chk("settle_edge", first, LAT1);
  endtask

  initial begin
    int pulses;
    int mode;
    logic [15:0] w;
    if2.i_start = 1'b0;
    if2.i_continuous = 1'b0;
    if2.i_abort = 1'b0;
    if1.i_start = 1'b0;
    if1.i_continuous = 1'b0;
    if1.i_abort = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_sel", 32'(if2.o_sel), 0);
    chk("rst_busy", 32'(if2.o_busy), 0);
    chk("rst_data", 32'(if2.o_data), 0);
    chk("rst_valid", 32'(if2.o_data_valid), 0);
    chk("rst_data1", 32'(if1.o_data), 0);
    rst_n = 1'b1;
    step();

    run_scan(16'hA5C3, -1);
    run_scan(16'hA5C3, 19);
    abort_scan(16'h5A5A, 21);

    if2.i_abort = 1'b1;
    if2.i_start = 1'b1;
    step();
    if2.i_abort = 1'b0;
    if2.i_start = 1'b0;
    chk("abort_start_idle", 32'(if2.o_busy), 0);
    step();
    chk("abort_start_idle2", 32'(if2.o_busy), 0);

    run_cont();

    for (int i = 0; i < 8; i++) begin
      w = 16'($urandom);
      mode = $urandom_range(0, 2);
      if (mode == 0)
        run_scan(w, -1);
      else if (mode == 1)
        run_scan(w, $urandom_range(1, 45));
      else
        abort_scan(w, $urandom_range(1, 47));
    end

    in2 = 16'hBEEF;
    if2.i_start = 1'b1;
    step();
    if2.i_start = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    repeat (3) step();
    chk("mid_rst_sel", 32'(if2.o_sel), 0);
    chk("mid_rst_busy", 32'(if2.o_busy), 0);
    chk("mid_rst_data", 32'(if2.o_data), 0);
    chk("mid_rst_valid", 32'(if2.o_data_valid), 0);
    rst_n = 1'b1;
    exp_data = '0;
    pulses = 0;
    repeat (60) begin
      step();
      if (if2.o_data_valid) pulses++;
    end
    chk("rst_no_valid", pulses, 0);

    run_scan1(16'h8001);
    run_scan1(16'($urandom));
    run_scan1(16'($urandom));

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
